// File: rtl/spdif_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// spdif_frame_scheduler_pkg
//
// Purpose:
//   Shared definitions for the S/PDIF frame scheduler: the default FIFO
//   depth, the channel-status block layout, the scheduler state enumeration
//   and a helper that returns a single channel-status bit for a frame.
//
// Contents:
//   DEPTH_DEFAULT     default FIFO depth in stereo pairs
//   FRAMES_PER_BLOCK  frames in one channel-status block (192)
//   CS_*              positions and codes inside the 192-bit status word
//   state_t           IDLE / PRIME / RUN
//   csStatusBit()     status bit for a given frame index and rate code
// ---------------------------------------------------------------------------
package spdif_frame_scheduler_pkg;

  localparam int DEPTH_DEFAULT    = 4;
  localparam int FRAMES_PER_BLOCK = 192;

  localparam int CS_COPY_BIT = 2;
  localparam int CS_RATE_LO  = 24;
  localparam int CS_RATE_HI  = 27;
  localparam int CS_WLEN_LO  = 32;
  localparam int CS_WLEN_HI  = 35;

  localparam logic [3:0] CS_WORD_LEN = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Returns status[idx] of the consumer-format channel-status word.
  // Only the copy-permitted bit, the sample-rate field and the word-length
  // field are ever non-zero. The rate field is carried LSB first (bit 24 is
  // rate[0]), while the word-length code is laid out in the word in the order
  // it is written (bit 32 is its leftmost digit, the "max 24 bit" flag).
  // Both fields start on a multiple of four, so idx[1:0] selects the digit.
  function automatic logic csStatusBit(input logic [7:0] idx,
                                       input logic [3:0] rate);
    logic       bitVal;
    logic [1:0] sel;
    bitVal = 1'b0;
    sel    = idx[1:0];
    if (idx == 8'(CS_COPY_BIT)) begin
      bitVal = 1'b1;
    end else if ((idx >= 8'(CS_RATE_LO)) && (idx <= 8'(CS_RATE_HI))) begin
      bitVal = rate[sel];
    end else if ((idx >= 8'(CS_WLEN_LO)) && (idx <= 8'(CS_WLEN_HI))) begin
      bitVal = CS_WORD_LEN[2'd3 - sel];
    end
    return bitVal;
  endfunction

endpackage

// File: rtl/spdif_pair_fifo.sv
// ---------------------------------------------------------------------------
// spdif_pair_fifo
//
// Purpose:
//   Small synchronous FIFO holding packed {left, right} stereo pairs for the
//   S/PDIF frame scheduler. Occupancy is kept in a register so that the
//   scheduler's ready and priming decisions never depend on same-cycle
//   push/pop activity.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_flush      synchronous clear of all contents (same effect as rst)
//   i_push       write i_push_data at the tail (ignored when full)
//   i_push_data  packed pair, left sample in the upper half
//   i_pop        drop the head entry (ignored when empty)
//   o_head_data  current head entry (valid while o_level != 0)
//   o_level      registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module spdif_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_level;
  logic             w_doPush;
  logic             w_doPop;

  // Requests are qualified here as well, so a stray push into a full FIFO or
  // a pop of an empty one can never corrupt the pointers. A pop on empty
  // does nothing, which lets a same-cycle push land normally.
  assign w_doPush = i_push && (r_level != (PW+1)'(DEPTH));
  assign w_doPop  = i_pop  && (r_level != '0);

  // Storage array. It is deliberately not reset: stale entries are never
  // visible because the pointers and level are cleared instead.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally. Simultaneous push and pop leave the level as is.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + (PW+1)'(1);
        2'b01:   r_level <= r_level - (PW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rdPtr];
  assign o_level     = r_level;

endmodule

// File: rtl/spdif_frame_scheduler.sv
// ---------------------------------------------------------------------------
// spdif_frame_scheduler
//
// Purpose:
//   Buffers stereo sample pairs from the I2S side and hands exactly one pair
//   to the S/PDIF transmitter per frame request. Tracks the 192-frame
//   channel-status block and serves the status bit of the current frame.
//   When the buffer runs dry during a frame it sends invalid silence, counts
//   the underrun and re-primes the buffer.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   i_enable            run request; low returns to IDLE and flushes
//   i_sample_rate_code  status bits 24..27, captured at each block start
//   i_s_valid/o_s_ready input pair handshake (ready = FIFO not full)
//   i_s_left/i_s_right  24-bit samples
//   i_frame_req         one-cycle pulse at the start of each frame
//   o_data_left/right   {8'h00, sample} for the transmitter
//   o_validity          1 = sample invalid (silence or idle)
//   o_cs_bit            channel-status bit of the current frame
//   o_block_start       high while the current frame index is 0
//   o_frame_idx         frame within the status block, 0..191
//   o_fifo_level        FIFO occupancy
//   o_underrun_count    saturating underrun counter
// ---------------------------------------------------------------------------
module spdif_frame_scheduler
  import spdif_frame_scheduler_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [3:0]              i_sample_rate_code,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic [23:0]             i_s_left,
  input  logic [23:0]             i_s_right,
  input  logic                    i_frame_req,
  output logic [31:0]             o_data_left,
  output logic [31:0]             o_data_right,
  output logic                    o_validity,
  output logic                    o_cs_bit,
  output logic                    o_block_start,
  output logic [7:0]              o_frame_idx,
  output logic [$clog2(DEPTH):0]  o_fifo_level,
  output logic [15:0]             o_underrun_count
);

  localparam int         LW         = $clog2(DEPTH) + 1;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

  state_t      r_state;
  state_t      w_nextState;

  logic [LW-1:0] w_level;
  logic [47:0]   w_head;
  logic          w_sReady;
  logic          w_push;
  logic          w_pop;
  logic          w_underrun;
  logic          w_flush;
  logic          w_frameStep;

  logic [7:0]    r_frameIdx;
  logic [7:0]    w_nextIdx;
  logic [3:0]    r_rate;

  logic [31:0]   r_dataLeft;
  logic [31:0]   r_dataRight;
  logic          r_validity;
  logic          r_csBit;
  logic          r_blockStart;
  logic [15:0]   r_underrunCount;

  // Ready comes from the registered level only, so a pop on a full FIFO
  // frees the slot for the producer one cycle later.
  assign w_sReady  = (w_level != LW'(DEPTH));
  assign w_nextIdx = (r_frameIdx == LAST_FRAME) ? 8'd0 : (r_frameIdx + 8'd1);

  spdif_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (48)
  ) u_pairFifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data ({i_s_left, i_s_right}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_level     (w_level)
  );

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-cycle control decode. Dropping enable wins over
  // everything else and flushes the FIFO on the same edge that enters IDLE.
  // IDLE keeps the FIFO flushed, so pushes offered there are discarded even
  // though ready is high. In PRIME frames still advance the block counter
  // but nothing is popped. In RUN a frame either pops the head or, if the
  // FIFO is empty, becomes an underrun and sends the FSM back to PRIME.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    w_flush     = 1'b0;
    w_frameStep = 1'b0;
    if (!i_enable) begin
      w_nextState = ST_IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nextState = ST_PRIME;
          w_flush     = 1'b1;
        end
        ST_PRIME: begin
          w_push      = i_s_valid && w_sReady;
          w_frameStep = i_frame_req;
          if (w_level >= LW'(PRIME_LEVEL)) begin
            w_nextState = ST_RUN;
          end
        end
        ST_RUN: begin
          w_push      = i_s_valid && w_sReady;
          w_frameStep = i_frame_req;
          if (i_frame_req) begin
            if (w_level != '0) begin
              w_pop = 1'b1;
            end else begin
              w_underrun  = 1'b1;
              w_nextState = ST_PRIME;
            end
          end
        end
        default: begin
          w_nextState = ST_IDLE;
          w_flush     = 1'b1;
        end
      endcase
    end
  end

  // Block position and the rate code used for the current block. The rate
  // is captured whenever the index becomes 0: continuously while flushed
  // (which covers the IDLE to PRIME entry) and on the 191 to 0 wrap, so a
  // rate change mid-block only shows up in the following block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameIdx <= 8'd0;
      r_rate     <= 4'd0;
    end else if (w_flush) begin
      r_frameIdx <= 8'd0;
      r_rate     <= i_sample_rate_code;
    end else if (w_frameStep) begin
      r_frameIdx <= w_nextIdx;
      if (w_nextIdx == 8'd0) begin
        r_rate <= i_sample_rate_code;
      end
    end
  end

  // Frame outputs, updated once per frame request and held until the next.
  // The status bit is looked up for the index the frame is moving to; at
  // index 0 it is 0 regardless of rate, so using the current block's rate
  // is correct even on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_dataLeft   <= 32'd0;
      r_dataRight  <= 32'd0;
      r_validity   <= 1'b1;
      r_csBit      <= 1'b0;
      r_blockStart <= 1'b1;
    end else if (w_frameStep) begin
      if (w_pop) begin
        r_dataLeft  <= {8'h00, w_head[47:24]};
        r_dataRight <= {8'h00, w_head[23:0]};
      end else begin
        r_dataLeft  <= 32'd0;
        r_dataRight <= 32'd0;
      end
      r_validity   <= !w_pop;
      r_csBit      <= csStatusBit(w_nextIdx, r_rate);
      r_blockStart <= (w_nextIdx == 8'd0);
    end
  end

  // Underrun counter. It survives enable drops and only clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrunCount <= 16'd0;
    end else if (w_underrun && (r_underrunCount != 16'hFFFF)) begin
      r_underrunCount <= r_underrunCount + 16'd1;
    end
  end

  assign o_s_ready        = w_sReady;
  assign o_data_left      = r_dataLeft;
  assign o_data_right     = r_dataRight;
  assign o_validity       = r_validity;
  assign o_cs_bit         = r_csBit;
  assign o_block_start    = r_blockStart;
  assign o_frame_idx      = r_frameIdx;
  assign o_fifo_level     = w_level;
  assign o_underrun_count = r_underrunCount;

endmodule

// File: tb/tb_spdif_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spdif_frame_scheduler
//
// Purpose:
//   Self-checking bench for spdif_frame_scheduler. A behavioural model built
//   from a queue of pairs, a frame counter and a 192-bit status word predicts
//   every output after every clock edge. Directed steps walk through priming,
//   draining, underrun, full-FIFO backpressure, a full status block with a
//   mid-block rate change, and reset/enable drops mid-run.
// ---------------------------------------------------------------------------
module tb_spdif_frame_scheduler;

  localparam int DEPTH       = 4;
  localparam int PRIME_LEVEL = 2;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_PRIME = 1;
  localparam int MODE_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  rateCode;
  logic        sValid;
  logic        sReady;
  logic [23:0] sLeft;
  logic [23:0] sRight;
  logic        frameReq;
  logic [31:0] dataLeft;
  logic [31:0] dataRight;
  logic        validity;
  logic        csBit;
  logic        blockStart;
  logic [7:0]  frameIdx;
  logic [2:0]  fifoLevel;
  logic [15:0] underrunCount;

  int compareCount = 0;
  int failCount    = 0;

  int          mMode;
  logic [47:0] mQ[$];
  int          mIdx;
  logic [3:0]  mRate;
  logic [31:0] mDataL;
  logic [31:0] mDataR;
  logic        mValidity;
  logic        mCs;
  logic        mBs;
  int          mUnder;
  int          popCount;
  bit          lastAccepted;
  bit          lastFr;
  logic [23:0] pendL;
  logic [23:0] pendR;

  spdif_frame_scheduler #(
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (PRIME_LEVEL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_enable           (enable),
    .i_sample_rate_code (rateCode),
    .i_s_valid          (sValid),
    .o_s_ready          (sReady),
    .i_s_left           (sLeft),
    .i_s_right          (sRight),
    .i_frame_req        (frameReq),
    .o_data_left        (dataLeft),
    .o_data_right       (dataRight),
    .o_validity         (validity),
    .o_cs_bit           (csBit),
    .o_block_start      (blockStart),
    .o_frame_idx        (frameIdx),
    .o_fifo_level       (fifoLevel),
    .o_underrun_count   (underrunCount)
  );

  always #5 clk = ~clk;

  // Channel-status bit straight from the documented word: copy bit 2, the
  // rate code in bits 24..27 (bit 24 = code LSB), and bits 32, 34, 35 set
  // for the 24-bit word-length code.
  function automatic logic statusBit(input int idx, input logic [3:0] rate);
    logic [191:0] word;
    word     = '0;
    word[2]  = 1'b1;
    for (int k = 0; k < 4; k++) word[24 + k] = rate[k];
    word[32] = 1'b1;
    word[34] = 1'b1;
    word[35] = 1'b1;
    return word[idx];
  endfunction

  task automatic modelIdleOutputs();
    mQ.delete();
    mIdx      = 0;
    mDataL    = 32'd0;
    mDataR    = 32'd0;
    mValidity = 1'b1;
    mCs       = 1'b0;
    mBs       = 1'b1;
  endtask

  // Advances the model across one clock edge using the inputs currently
  // being driven.
  task automatic modelStep();
    int  size;
    bit  doPush;
    bit  doPop;
    bit  doUnder;
    lastAccepted = 1'b0;
    if (rst) begin
      mMode  = MODE_IDLE;
      mRate  = 4'd0;
      mUnder = 0;
      modelIdleOutputs();
    end else if (!enable || (mMode == MODE_IDLE)) begin
      mMode = enable ? MODE_PRIME : MODE_IDLE;
      mRate = rateCode;
      modelIdleOutputs();
    end else begin
      size    = mQ.size();
      doPush  = sValid && (size < DEPTH);
      doPop   = (mMode == MODE_RUN) && frameReq && (size > 0);
      doUnder = (mMode == MODE_RUN) && frameReq && (size == 0);
      if (frameReq) begin
        mIdx = (mIdx + 1) % 192;
        if (mIdx == 0) mRate = rateCode;
        if (doPop) begin
          mDataL = {8'h00, mQ[0][47:24]};
          mDataR = {8'h00, mQ[0][23:0]};
        end else begin
          mDataL = 32'd0;
          mDataR = 32'd0;
        end
        mValidity = !doPop;
        mCs       = statusBit(mIdx, mRate);
        mBs       = (mIdx == 0);
      end
      if ((mMode == MODE_PRIME) && (size >= PRIME_LEVEL)) begin
        mMode = MODE_RUN;
      end else if (doUnder) begin
        mMode = MODE_PRIME;
        if (mUnder < 65535) mUnder++;
      end
      if (doPop) begin
        void'(mQ.pop_front());
        popCount++;
      end
      if (doPush) begin
        mQ.push_back({sLeft, sRight});
        lastAccepted = 1'b1;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("data_left",      dataLeft,                 mDataL);
    cmp("data_right",     dataRight,                mDataR);
    cmp("validity",       32'(validity),            32'(mValidity));
    cmp("cs_bit",         32'(csBit),               32'(mCs));
    cmp("block_start",    32'(blockStart),          32'(mBs));
    cmp("frame_idx",      32'(frameIdx),            32'(mIdx));
    cmp("fifo_level",     32'(fifoLevel),           32'(mQ.size()));
    cmp("s_ready",        32'(sReady),              32'(mQ.size() != DEPTH));
    cmp("underrun_count", 32'(underrunCount),       32'(mUnder));
  endtask

  // Drives one cycle of inputs (pair data from pendL/pendR), advances the
  // model, clocks the DUT and compares all outputs 1 time unit after the
  // edge. Consecutive frame requests are suppressed to keep spacing legal.
  task automatic applyStimulus(input bit r, input bit en, input bit sv,
                               input bit fr, input logic [3:0] code);
    if (fr && lastFr) fr = 1'b0;
    rst      = r;
    enable   = en;
    sValid   = sv;
    frameReq = fr;
    rateCode = code;
    sLeft    = pendL;
    sRight   = pendR;
    lastFr   = fr;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic randomCycle(input bit r, input bit en, input bit sv,
                             input bit fr, input logic [3:0] code);
    applyStimulus(r, en, sv, fr, code);
    if (lastAccepted) begin
      pendL = 24'($urandom);
      pendR = 24'($urandom);
    end
  endtask

  initial begin
    int   startPops;
    int   cycles;
    int   ones1;
    int   ones2;
    int   wraps;
    int   prevIdx;
    bit   sawNotReady;
    logic [3:0] curCode;

    rst = 1'b1; enable = 1'b0; rateCode = 4'd0; sValid = 1'b0;
    sLeft = '0; sRight = '0; frameReq = 1'b0;
    pendL = '0; pendR = '0; lastFr = 1'b0; popCount = 0;
    mMode = MODE_IDLE; mRate = 4'd0; mUnder = 0;
    modelIdleOutputs();

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 4'd0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    cmp("reset_validity",    32'(validity),    32'd1);
    cmp("reset_block_start", 32'(blockStart),  32'd1);
    cmp("reset_s_ready",     32'(sReady),      32'd1);

    $display("[TB] enable with no input, stays in PRIME");
    applyStimulus(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, (i % 3) == 0, 4'd0);
    cmp("prime_no_underrun", 32'(underrunCount), 32'd0);
    cmp("prime_validity",    32'(validity),      32'd1);

    $display("[TB] two pairs, then drain and underrun");
    pendL = 24'h000001; pendR = 24'hFFFFFF;
    applyStimulus(0, 1, 1, 0, 4'd0);
    pendL = 24'h000002; pendR = 24'h000003;
    applyStimulus(0, 1, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 1, 4'd0);
    cmp("first_pop_left",  dataLeft,        32'h00000001);
    cmp("first_pop_right", dataRight,       32'h00FFFFFF);
    cmp("first_pop_valid", 32'(validity),   32'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 1, 4'd0);
    cmp("second_pop_left", dataLeft,        32'h00000002);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 1, 4'd0);
    cmp("underrun_data",     dataLeft,           32'h0);
    cmp("underrun_validity", 32'(validity),      32'd1);
    cmp("underrun_count",    32'(underrunCount), 32'd1);

    $display("[TB] backpressure with s_valid held high for 1000 pairs");
    applyStimulus(0, 0, 0, 0, 4'd0);
    pendL = 24'($urandom); pendR = 24'($urandom);
    startPops   = popCount;
    cycles      = 0;
    sawNotReady = 1'b0;
    while (((popCount - startPops) < 1000) && (cycles < 20000)) begin
      randomCycle(0, 1, 1, $urandom_range(99) < 45, 4'd3);
      if (sReady === 1'b0) sawNotReady = 1'b1;
      cycles++;
    end
    cmp("pairs_within_budget", 32'((popCount - startPops) >= 1000), 32'd1);
    cmp("s_ready_deasserted",  32'(sawNotReady),                   32'd1);

    $display("[TB] channel-status block with mid-block rate change");
    applyStimulus(0, 0, 0, 0, 4'd0);
    curCode = 4'b1110;
    applyStimulus(0, 1, 0, 0, curCode);
    ones1 = 0; ones2 = 0; wraps = 0; prevIdx = 0;
    for (int f = 1; f <= 384; f++) begin
      if (f == 100) curCode = 4'b0101;
      randomCycle(0, 1, $urandom_range(99) < 50, 1, curCode);
      if ((frameIdx == 8'd0) && (prevIdx == 191)) wraps++;
      if (f <= 191) ones1 += int'(csBit);
      else          ones2 += int'(csBit);
      prevIdx = int'(frameIdx);
      randomCycle(0, 1, $urandom_range(99) < 50, 0, curCode);
    end
    cmp("block1_cs_ones", 32'(ones1), 32'd7);
    cmp("block2_cs_ones", 32'(ones2), 32'd6);
    cmp("block_wraps",    32'(wraps), 32'd2);

    $display("[TB] reset mid-RUN with three pairs queued");
    applyStimulus(0, 0, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 1, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      pendL = 24'($urandom); pendR = 24'($urandom);
      applyStimulus(0, 1, 1, 0, 4'd0);
    end
    cmp("queued_level", 32'(fifoLevel), 32'd3);
    applyStimulus(1, 1, 0, 0, 4'd0);
    cmp("rst_level",     32'(fifoLevel),     32'd0);
    cmp("rst_frame_idx", 32'(frameIdx),      32'd0);
    cmp("rst_validity",  32'(validity),      32'd1);
    cmp("rst_underruns", 32'(underrunCount), 32'd0);

    $display("[TB] enable drop mid-RUN with three pairs queued");
    applyStimulus(0, 1, 0, 0, 4'd0);
    pendL = 24'h00000A; pendR = 24'h00000B;
    applyStimulus(0, 1, 1, 0, 4'd0);
    pendL = 24'h00000C; pendR = 24'h00000D;
    applyStimulus(0, 1, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 4'd0);
      applyStimulus(0, 1, 0, 0, 4'd0);
    end
    for (int i = 0; i < 3; i++) begin
      pendL = 24'($urandom); pendR = 24'($urandom);
      applyStimulus(0, 1, 1, 0, 4'd0);
    end
    cmp("queued_level_2", 32'(fifoLevel), 32'd3);
    applyStimulus(0, 0, 0, 0, 4'd0);
    cmp("dis_level",     32'(fifoLevel),     32'd0);
    cmp("dis_frame_idx", 32'(frameIdx),      32'd0);
    cmp("dis_validity",  32'(validity),      32'd1);
    cmp("dis_underruns", 32'(underrunCount), 32'd1);

    $display("[TB] random traffic");
    pendL = 24'($urandom); pendR = 24'($urandom);
    for (int i = 0; i < 1500; i++) begin
      randomCycle($urandom_range(999) < 3,
                  $urandom_range(999) >= 8,
                  $urandom_range(99) < 40,
                  $urandom_range(99) < 40,
                  4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/spdif_frame_scheduler.md
# spdif_frame_scheduler

Schedules stereo samples into the S/PDIF transmit datapath. It buffers incoming left/right sample pairs in a small FIFO and releases exactly one pair per transmit frame on the transmitter's frame request. It tracks the 192-frame channel-status block and serves the per-frame channel-status bit. On FIFO underrun it substitutes silence flagged invalid. It sits between the I2S receive side and the S/PDIF transmitter.

## Interface
- DEPTH, 4: FIFO depth in stereo pairs; power of two, at least 2.
- PRIME_LEVEL, 2: FIFO level required before leaving PRIME; range 1..DEPTH.
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- enable  in  1  run request; low forces IDLE.
- sample_rate_code  in  4  channel-status bits 24..27; sampled at block start.
- s_valid  in  1  input pair valid.
- s_ready  out  1  FIFO can accept; equals (level != DEPTH).
- s_left  in  24  left sample.
- s_right  in  24  right sample.
- frame_req  in  1  one-cycle pulse from the transmitter at the start of each frame (left subframe).
- data_left  out  32  {8'h00, left sample} to the transmitter.
- data_right  out  32  {8'h00, right sample}.
- validity  out  1  1 = sample invalid (silence or idle).
- cs_bit  out  1  channel-status bit for the current frame; same on both channels.
- block_start  out  1  high while frame_idx == 0 (B-preamble frame).
- frame_idx  out  8  0..191 frame within the block.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.
- underrun_count  out  16  saturating count of underruns.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - FIFO flushed (level 0); s_ready held high, but pushes are discarded.
  - Outputs are zero data with validity=1.
  - enable=1 moves to PRIME on the next cycle.
- PRIME:
  - Pushes accepted.
  - frame_req outputs zero data with validity=1 and pops nothing.
  - Moves to RUN when level >= PRIME_LEVEL.
- RUN, frame_req with level > 0: pop the head entry; drive it with validity=0.
- RUN, frame_req with level == 0:
  - Underrun: drive zero data with validity=1.
  - underrun_count increments, saturating at 16'hFFFF.
  - Next state is PRIME.
- enable=0 in any state goes to IDLE on the next cycle and flushes the FIFO.
- FIFO push happens when s_valid && s_ready (not IDLE).
- Push and pop in the same cycle:
  - Level unchanged if it was non-empty.
  - If full, the pop frees the slot only from the next cycle, since s_ready is computed from the registered level.
  - A pop on empty never bypasses a same-cycle push; that push still lands and counts as an underrun.
- Block tracking:
  - frame_idx advances on every frame_req while enable=1, wrapping 191→0; it is reset to 0 in IDLE.
  - sample_rate_code is latched into the block register when frame_idx becomes 0 (including the IDLE→PRIME entry), so one block is always consistent.
- Channel-status word (192 bits, consumer format); all bits not listed below are 0:
  - bit0=0, bit1=0, bit2=1 (copy permitted).
  - bits 24..27 = latched sample_rate_code.
  - bits 32..35 = 4'b1011 (24-bit word length).
- cs_bit = status[frame_idx].

## Timing
- Reset values:
  - state IDLE, level 0, frame_idx 0.
  - data_left/right 0, validity 1, cs_bit 0, block_start 1.
  - underrun_count 0, s_ready 1.
- frame_req in cycle t: data, validity, frame_idx, cs_bit and block_start are updated registered at t+1 and held until the next frame_req.
- The transmitter must sample data on its next subframe boundary, at least 2 cycles after frame_req.
- Push at cycle t is visible in fifo_level at t+1 and poppable from t+1.
- Minimum frame_req spacing is 2 cycles. Back-to-back pulses are illegal and need not be handled.
- rst mid-operation overrides everything in the same edge. Any in-flight pair is lost and the counter is not incremented.

## Structure
- Shared package: DEPTH default, the channel-status constants (word-length code 4'b1011, copy bit index 2, rate field 24..27), and the state enumeration.
- Sub-module spdif_pair_fifo: a 48-bit-wide synchronous FIFO with push/pop/level and a registered level. The scheduler FSM and block counter stay in the top.

## Test plan
- Reset, then enable with no input → validity=1 and zero data on every frame_req; stays in PRIME; underrun_count stays 0.
- Push pairs (L=24'h000001,R=24'hFFFFFF), (2,3) → RUN. Next two frame_req give data_left=32'h00000001/32'h00000002 with validity=0.
- In RUN, drain the FIFO, then frame_req → zero data, validity=1, underrun_count=1, state back to PRIME.
- Keep 4 entries with s_valid held high → s_ready=0. A frame_req pop raises s_ready one cycle later; no data is dropped or duplicated across 1000 pairs (scoreboard).
- Issue 192 frame_reqs with sample_rate_code=4'b1110:
  - block_start is high only when frame_idx=0, and frame_idx wraps 191→0.
  - cs_bit is 1 at frame_idx 2, 25, 26, 27, 32, 34, 35 and 0 elsewhere.
  - A rate change mid-block takes effect only from the next block.
- Assert rst or drop enable mid-RUN with 3 entries queued → next cycle: level 0, frame_idx 0, validity=1. Under rst, underrun_count is 0; with enable=0, it is held.
